// File: rtl/tmds_link_sequencer.sv
// tmds_link_sequencer
//   Sits between the read side of the 40-bit TMDS async FIFO and the four 5-bit LVDS
//   serializers, in the data-load clock domain (2x pixel rate). It owns the FIFO read
//   enable and the 10->5 gearbox, and emits a valid idle TMDS stream whenever it is
//   not streaming: while the FIFO primes, after a drain, and after an underflow.
//
// Ports
//   clock, asyncResetN       data-load clock, asynchronous active-low reset
//   enable                   request to stream FIFO data
//   fifoEmpty, fifoData      FWFT FIFO head: {chC, ch2, ch1, ch0}, 10 bits each
//   fifoReadEnable           pops the FIFO at the clock edge (RUN, high half only)
//   lvds{0,1,2,C}Data        serializer half-words; low half [4:0] on phase 0,
//                            high half [9:5] on phase 1
//   linkActive               high on cycles whose lanes carry FIFO data
//   underflowPulse           one-cycle pulse per underflow
//   underflowCount           saturating underflow counter
module tmds_link_sequencer #(
  parameter int unsigned FILL_CYCLES     = 8,
  parameter int unsigned COUNT_WIDTH     = 8,
  parameter logic [9:0]  IDLE_DATA_WORD  = 10'b1101010100,
  parameter logic [9:0]  IDLE_CLOCK_WORD = 10'b0000011111
) (
  input  logic                   clock,
  input  logic                   asyncResetN,
  input  logic                   enable,
  input  logic                   fifoEmpty,
  input  logic [39:0]            fifoData,
  output logic                   fifoReadEnable,
  output logic [4:0]             lvds0Data,
  output logic [4:0]             lvds1Data,
  output logic [4:0]             lvds2Data,
  output logic [4:0]             lvdsCData,
  output logic                   linkActive,
  output logic                   underflowPulse,
  output logic [COUNT_WIDTH-1:0] underflowCount
);

  localparam int unsigned         FillW   = $clog2(FILL_CYCLES + 1);
  localparam logic [FillW-1:0]    FillMax = FillW'(FILL_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun,
    StUnderflow
  } state_e;

  state_e                 state_q, state_d;
  logic                   phase_q;
  logic [FillW-1:0]       fill_q, fill_d;
  logic [3:0][4:0]        lane_q, lane_d;
  logic                   active_q, active_d;
  logic                   pulse_q, pulse_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  // Half-word candidates for the current phase; lane 3 is the clock channel.
  logic [3:0][4:0]        data_half;
  logic [3:0][4:0]        idle_half;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      data_half[k] = phase_q ? fifoData[10*k+5 +: 5] : fifoData[10*k +: 5];
    end
    idle_half[0] = phase_q ? IDLE_DATA_WORD[9:5] : IDLE_DATA_WORD[4:0];
    idle_half[1] = idle_half[0];
    idle_half[2] = idle_half[0];
    idle_half[3] = phase_q ? IDLE_CLOCK_WORD[9:5] : IDLE_CLOCK_WORD[4:0];
  end

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    lane_d   = idle_half;
    active_d = 1'b0;
    pulse_d  = 1'b0;
    count_d  = count_q;

    unique case (state_q)
      StIdle: begin
        fill_d = '0;
        if (enable) begin
          state_d = StFill;
        end
      end

      StFill: begin
        if (!enable) begin
          state_d = StIdle;
          fill_d  = '0;
        end else begin
          // Any empty cycle restarts priming; the count saturates at the threshold.
          if (fifoEmpty) begin
            fill_d = '0;
          end else if (fill_q < FillMax) begin
            fill_d = fill_q + 1'b1;
          end
          // Leave only from phase 1 so that RUN always starts on a low half.
          if (fill_q >= FillMax && phase_q) begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        fill_d = '0;
        if (!phase_q && fifoEmpty) begin
          pulse_d = 1'b1;
          state_d = StUnderflow;
          if (count_q != '1) begin
            count_d = count_q + 1'b1;
          end
        end else begin
          // A word seen non-empty on phase 0 stays at the FIFO head until popped on
          // phase 1, so the high half needs no emptiness check.
          lane_d   = data_half;
          active_d = 1'b1;
          if (phase_q && !enable) begin
            state_d = StIdle;
          end
        end
      end

      StUnderflow: begin
        // Always phase 1: finish the idle symbol, then re-prime.
        fill_d  = '0;
        state_d = StFill;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge asyncResetN) begin
    if (!asyncResetN) begin
      state_q  <= StIdle;
      phase_q  <= 1'b0;
      fill_q   <= '0;
      lane_q   <= {IDLE_CLOCK_WORD[4:0], IDLE_DATA_WORD[4:0], IDLE_DATA_WORD[4:0],
                   IDLE_DATA_WORD[4:0]};
      active_q <= 1'b0;
      pulse_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= ~phase_q;
      fill_q   <= fill_d;
      lane_q   <= lane_d;
      active_q <= active_d;
      pulse_q  <= pulse_d;
      count_q  <= count_d;
    end
  end

  // Decoded from registered state so the pop is known before the edge it happens on.
  assign fifoReadEnable = (state_q == StRun) && phase_q;

  assign lvds0Data      = lane_q[0];
  assign lvds1Data      = lane_q[1];
  assign lvds2Data      = lane_q[2];
  assign lvdsCData      = lane_q[3];
  assign linkActive     = active_q;
  assign underflowPulse = pulse_q;
  assign underflowCount = count_q;

endmodule

// File: tb/tb_tmds_link_sequencer.sv
module tb_tmds_link_sequencer;

  localparam int unsigned FillCycles = 8;
  localparam int unsigned CountWidth = 2;
  localparam int          CountMax   = (1 << CountWidth) - 1;
  localparam logic [9:0]  IdleData   = 10'b1101010100;
  localparam logic [9:0]  IdleClock  = 10'b0000011111;

  localparam int ModeIdle    = 0;
  localparam int ModeFill    = 1;
  localparam int ModeStream  = 2;
  localparam int ModeRecover = 3;

  logic                  clock = 1'b0;
  logic                  asyncResetN;
  logic                  enable;
  logic                  fifoEmpty;
  logic [39:0]           fifoData;
  logic                  fifoReadEnable;
  logic [4:0]            lvds0Data, lvds1Data, lvds2Data, lvdsCData;
  logic                  linkActive;
  logic                  underflowPulse;
  logic [CountWidth-1:0] underflowCount;

  always #5 clock = ~clock;

  tmds_link_sequencer #(
    .FILL_CYCLES     (FillCycles),
    .COUNT_WIDTH     (CountWidth),
    .IDLE_DATA_WORD  (IdleData),
    .IDLE_CLOCK_WORD (IdleClock)
  ) dut (
    .clock          (clock),
    .asyncResetN    (asyncResetN),
    .enable         (enable),
    .fifoEmpty      (fifoEmpty),
    .fifoData       (fifoData),
    .fifoReadEnable (fifoReadEnable),
    .lvds0Data      (lvds0Data),
    .lvds1Data      (lvds1Data),
    .lvds2Data      (lvds2Data),
    .lvdsCData      (lvdsCData),
    .linkActive     (linkActive),
    .underflowPulse (underflowPulse),
    .underflowCount (underflowCount)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO stand-in: FWFT queue, emptiness can only appear by popping or by force.
  logic [39:0] fifo_q[$];
  bit          force_empty = 0;
  bit          hold_mode   = 0;
  logic [39:0] hold_word;

  // Reference model: link mode, symbol half and priming progress.
  int          m_mode, m_phase, m_fill, m_count;
  logic [4:0]  m_lane[4];
  bit          m_active, m_pulse;

  int pulses_seen = 0;
  int pops_seen   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got no event, expected event (t=%0t)", name, $time);
  endtask

  task automatic model_reset();
    m_mode   = ModeIdle;
    m_phase  = 0;
    m_fill   = 0;
    m_count  = 0;
    m_active = 0;
    m_pulse  = 0;
    for (int k = 0; k < 4; k++) m_lane[k] = (k == 3) ? IdleClock[4:0] : IdleData[4:0];
  endtask

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic model_step(input bit en, input bit empty, input logic [39:0] data);
    int ph       = m_phase;
    int old_fill = m_fill;
    bit carry    = 0;
    m_pulse  = 0;
    m_active = 0;
    case (m_mode)
      ModeIdle: begin
        m_fill = 0;
        if (en) m_mode = ModeFill;
      end
      ModeFill: begin
        if (!en) begin
          m_mode = ModeIdle;
          m_fill = 0;
        end else begin
          if (empty) m_fill = 0;
          else if (m_fill < FillCycles) m_fill = m_fill + 1;
          if (old_fill >= FillCycles && ph == 1) m_mode = ModeStream;
        end
      end
      ModeStream: begin
        if (ph == 0 && empty) begin
          m_pulse = 1;
          m_count = (m_count < CountMax) ? m_count + 1 : CountMax;
          m_mode  = ModeRecover;
        end else begin
          carry    = 1;
          m_active = 1;
          if (ph == 1 && !en) m_mode = ModeIdle;
        end
      end
      default: begin
        m_fill = 0;
        m_mode = ModeFill;
      end
    endcase
    for (int k = 0; k < 4; k++) begin
      int w;
      if (carry) w = int'(data[10*k +: 10]);
      else w = (k == 3) ? int'(IdleClock) : int'(IdleData);
      m_lane[k] = 5'((w >> (5 * ph)) & 31);
    end
    m_phase = 1 - ph;
  endtask

  task automatic present_fifo();
    fifoEmpty = force_empty || (fifo_q.size() == 0);
    fifoData  = (fifo_q.size() > 0) ? fifo_q[0] : {8'($urandom), 32'($urandom)};
  endtask

  task automatic check_outputs();
    chk("lvds0Data", lvds0Data, m_lane[0]);
    chk("lvds1Data", lvds1Data, m_lane[1]);
    chk("lvds2Data", lvds2Data, m_lane[2]);
    chk("lvdsCData", lvdsCData, m_lane[3]);
    chk("linkActive", linkActive, m_active);
    chk("underflowPulse", underflowPulse, m_pulse);
    chk("underflowCount", underflowCount, m_count);
  endtask

  // One clock: present inputs, check the decoded pop, step model, check registers.
  task automatic cycle();
    bit ren;
    present_fifo();
    chk("fifoReadEnable", fifoReadEnable, (m_mode == ModeStream && m_phase == 1));
    ren = fifoReadEnable;
    chk("pop_on_empty", ren & fifoEmpty, 0);
    model_step(enable, fifoEmpty, fifoData);
    @(posedge clock);
    if (ren && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pops_seen++;
    end
    #1;
    if (underflowPulse) pulses_seen++;
    check_outputs();
    force_empty = 0;
    if (hold_mode) while (fifo_q.size() < 4) fifo_q.push_back(hold_word);
  endtask

  // Called just after cycle(): reset lands mid-cycle, away from both clock edges.
  task automatic pulse_reset();
    #2 asyncResetN = 1'b0;
    #1;
    chk("rst_lvds0", lvds0Data, 5'b10100);
    chk("rst_lvds1", lvds1Data, 5'b10100);
    chk("rst_lvds2", lvds2Data, 5'b10100);
    chk("rst_lvdsC", lvdsCData, 5'b11111);
    chk("rst_ren", fifoReadEnable, 0);
    chk("rst_active", linkActive, 0);
    chk("rst_pulse", underflowPulse, 0);
    chk("rst_count", underflowCount, 0);
    model_reset();
    #2 asyncResetN = 1'b1;
  endtask

  task automatic wait_stream_phase0(input string name);
    int n = 0;
    while (!(m_mode == ModeStream && m_phase == 0) && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) timeout(name);
  endtask

  task automatic wait_active(input string name, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!linkActive && n < 200);
    if (n >= 200) timeout(name);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0, u0, rate;
    asyncResetN = 1'b0;
    enable      = 1'b0;
    fifoEmpty   = 1'b1;
    fifoData    = '0;
    hold_word   = {10'h3FF, 10'h2AA, 10'h155, 10'h0F0};
    model_reset();

    // Reset state and idle alternation with enable low.
    #12;
    chk("reset_lvds0", lvds0Data, 5'b10100);
    chk("reset_lvdsC", lvdsCData, 5'b11111);
    chk("reset_ren", fifoReadEnable, 0);
    chk("reset_count", underflowCount, 0);
    asyncResetN = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      chk("idle_alt_data", lvds0Data, (i % 2 == 1) ? 5'b10100 : 5'b11010);
      chk("idle_alt_clock", lvdsCData, (i % 2 == 1) ? 5'b11111 : 5'b00000);
    end

    // Prime with a held word, then stream it.
    hold_mode = 1;
    while (fifo_q.size() < 4) fifo_q.push_back(hold_word);
    enable = 1'b1;
    wait_active("first_active", n);
    chk("first_active_latency", n, 11);
    chk("stream_lo_ch0", lvds0Data, 5'h10);
    chk("stream_lo_ch1", lvds1Data, 5'h15);
    chk("stream_lo_ch2", lvds2Data, 5'h0A);
    chk("stream_lo_chC", lvdsCData, 5'h1F);
    cycle();
    chk("stream_hi_ch0", lvds0Data, 5'h07);
    chk("stream_hi_ch1", lvds1Data, 5'h0A);
    chk("stream_hi_ch2", lvds2Data, 5'h15);
    chk("stream_hi_chC", lvdsCData, 5'h1F);
    p0 = pops_seen;
    repeat (20) cycle();
    chk("pops_per_20_cycles", pops_seen - p0, 10);

    // Underflow on a phase-0 RUN cycle, then re-prime.
    wait_stream_phase0("underflow_wait");
    force_empty = 1;
    cycle();
    chk("uf_pulse", underflowPulse, 1);
    chk("uf_count", underflowCount, 1);
    chk("uf_idle_lo", lvds0Data, 5'b10100);
    chk("uf_active", linkActive, 0);
    cycle();
    chk("uf_pulse_width", underflowPulse, 0);
    chk("uf_idle_hi", lvds0Data, 5'b11010);
    n = 1;
    do begin
      cycle();
      n++;
    end while (!linkActive && n < 200);
    if (n >= 200) timeout("uf_relatch");
    chk("uf_relatch_latency", n, 12);

    // Drop enable on the phase-0 data cycle: the word still completes.
    wait_stream_phase0("drop_wait");
    enable = 1'b0;
    cycle();
    chk("drop_lo_active", linkActive, 1);
    chk("drop_lo_data", lvds0Data, 5'h10);
    p0 = pops_seen;
    cycle();
    chk("drop_hi_active", linkActive, 1);
    chk("drop_hi_data", lvds0Data, 5'h07);
    chk("drop_pop", pops_seen - p0, 1);
    cycle();
    chk("drop_idle_active", linkActive, 0);
    chk("drop_idle_data", lvds0Data, 5'b10100);

    // Reset while RUN is about to present a low half.
    enable = 1'b1;
    wait_stream_phase0("reset_run_wait");
    p0 = pops_seen;
    enable = 1'b0;
    pulse_reset();
    chk("reset_run_no_pop", pops_seen - p0, 0);
    cycle();
    chk("post_reset_phase0", lvds0Data, 5'b10100);
    cycle();
    chk("post_reset_phase1", lvds0Data, 5'b11010);

    // Five underflows saturate a 2-bit counter while every pulse still fires.
    enable = 1'b1;
    u0 = pulses_seen;
    repeat (5) begin
      wait_stream_phase0("sat_wait");
      force_empty = 1;
      cycle();
    end
    chk("sat_count", underflowCount, 3);
    chk("sat_pulses", pulses_seen - u0, 5);

    // Random traffic: bursty pushes, enable toggles, occasional mid-cycle resets.
    hold_mode = 0;
    rate = 60;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) rate = $urandom_range(35, 95);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(1, 100) <= rate && fifo_q.size() < 16) begin
        fifo_q.push_back({8'($urandom), 32'($urandom)});
      end
      cycle();
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
